// File: rtl/seq_pkg.sv
// Shared types and the beat-period helper for the beat sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef logic [1:0] speed_t;

  // Clock cycles per beat at rate BASE_HZ << k; evaluated at elaboration only.
  function automatic logic [31:0] period_of(input int clk_hz, input int base_hz, input int k);
    return 32'(clk_hz / (base_hz << k));
  endfunction

endpackage

// File: rtl/tempo_counter.sv
// Beat-period counter: holds cnt and the latched speed, flags the beat boundary and the articulation gap.
module tempo_counter
  import seq_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BASE_HZ    = 1,
  parameter int GAP_CYCLES = 5_000_000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   load,
  input  logic   run,
  input  speed_t speed,
  output logic   boundary,
  output logic   in_gap
);

  localparam logic [31:0] P0  = period_of(CLK_HZ, BASE_HZ, 0);
  localparam logic [31:0] P1  = period_of(CLK_HZ, BASE_HZ, 1);
  localparam logic [31:0] P2  = period_of(CLK_HZ, BASE_HZ, 2);
  localparam logic [31:0] P3  = period_of(CLK_HZ, BASE_HZ, 3);
  localparam logic [31:0] GAP = 32'(GAP_CYCLES);

  logic [31:0] cnt;
  speed_t      spd_q;
  logic [31:0] period;
  logic        at_last;

  always_comb begin
    period = P0;
    case (spd_q)
      2'd0:    period = P0;
      2'd1:    period = P1;
      2'd2:    period = P2;
      default: period = P3;
    endcase
  end

  assign at_last  = (cnt == period - 32'd1);
  assign boundary = run && at_last;
  assign in_gap   = (cnt >= period - GAP);

  // clear (start/stop) beats run, so a restart on a boundary edge wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= 32'd0;
      spd_q <= 2'd0;
    end else if (clear) begin
      cnt <= 32'd0;
      if (load) spd_q <= speed;
    end else if (run) begin
      if (at_last) begin
        cnt   <= 32'd0;
        spd_q <= speed;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Tempo-driven note sequencer: play/pause/stop FSM stepping beat_idx through a melody.
module beat_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BASE_HZ    = 1,
  parameter int LAST_IDX   = 14,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             dir,
  input  logic [1:0]       speed,
  input  logic             loop,
  output logic [IDX_W-1:0] beat_idx,
  output logic             beat_tick,
  output logic             mute,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

  state_t           state;
  logic             run;
  logic             boundary;
  logic             in_gap;
  logic [IDX_W-1:0] nxt_idx;
  logic             seq_end;

  // A pause pulse freezes the counter on the very edge it is sampled.
  assign run = (state == ST_PLAY) && !pause;

  tempo_counter #(
    .CLK_HZ    (CLK_HZ),
    .BASE_HZ   (BASE_HZ),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_tempo (
    .clk     (clk),
    .rst     (rst),
    .clear   (start || stop),
    .load    (start && !stop),
    .run     (run),
    .speed   (speed),
    .boundary(boundary),
    .in_gap  (in_gap)
  );

  always_comb begin
    nxt_idx = beat_idx;
    seq_end = 1'b0;
    if (!dir) begin
      if (beat_idx < LAST)  nxt_idx = beat_idx + 1'b1;
      else if (loop)        nxt_idx = '0;
      else                  seq_end = 1'b1;
    end else begin
      if (beat_idx > '0)    nxt_idx = beat_idx - 1'b1;
      else if (loop)        nxt_idx = LAST;
      else                  seq_end = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      beat_idx  <= '0;
      beat_tick <= 1'b0;
      done      <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        beat_idx <= '0;
      end else if (start) begin
        state    <= ST_PLAY;
        beat_idx <= dir ? LAST : '0;
      end else if (pause && state == ST_PLAY) begin
        state <= ST_PAUSE;
      end else if (pause && state == ST_PAUSE) begin
        state <= ST_PLAY;
      end else if (boundary) begin
        if (seq_end) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end else begin
          beat_idx  <= nxt_idx;
          beat_tick <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign mute = (state != ST_PLAY) || in_gap;

endmodule
